// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet round-robin arbiter feeding one uart_tx byte stream
// Each packet owns the output until its tlast beat; an optional header byte names the source.
module uart_tx_arb #(
   parameter int         N_SRC      = 4,
   parameter int         DATA_WIDTH = 8,
   parameter bit         HEADER_EN  = 1'b1,
   parameter logic [3:0] HDR_SYNC   = 4'hA
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [N_SRC-1:0]            s_tvalid,
   input  logic [N_SRC-1:0]            s_tlast,
   output logic [N_SRC-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]       m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic [N_SRC-1:0]            grant,
   output logic                        busy
);

   localparam int IDX_W = $clog2(N_SRC);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA
   } state_t;

   state_t                state_q, state_d;
   logic [N_SRC-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] hdr_q, hdr_d;

   logic                  req_found;
   logic [IDX_W-1:0]      req_idx;
   logic [IDX_W-1:0]      cand;
   logic [7:0]            hdr_byte;

   // ptr_q is both the round-robin start point and the index of the current owner.
   always_comb begin
      req_found = 1'b0;
      req_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % N_SRC);
         if (!req_found && s_tvalid[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
   end

   assign hdr_byte = {HDR_SYNC, 4'(req_idx)};

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      hdr_d   = hdr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_found) begin
               grant_d = N_SRC'(1) << req_idx;
               ptr_d   = req_idx;
               hdr_d   = DATA_WIDTH'(hdr_byte);
               state_d = HEADER_EN ? ST_HDR : ST_DATA;
            end
         end
         ST_HDR: begin
            if (m_tready) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (s_tvalid[ptr_q] && m_tready && s_tlast[ptr_q]) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= IDX_W'(N_SRC - 1);
         hdr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hdr_q   <= hdr_d;
      end
   end

   // Payload is not re-registered: the granted source drives the UART side directly.
   always_comb begin
      m_tdata  = hdr_q;
      m_tvalid = 1'b0;
      s_tready = '0;
      unique case (state_q)
         ST_HDR: m_tvalid = 1'b1;
         ST_DATA: begin
            for (int i = 0; i < N_SRC; i++) begin
               if (ptr_q == IDX_W'(i)) m_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            m_tvalid = s_tvalid[ptr_q];
            s_tready = grant_q & {N_SRC{m_tready}};
         end
         default: ;
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed bench for uart_tx_arb with a per-cycle reference model
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tvalid, m_tready;
   logic [N-1:0]    grant;
   logic            busy;

   always #5 clk = ~clk;

   uart_tx_arb #(.N_SRC(N), .DATA_WIDTH(DW), .HEADER_EN(1'b1), .HDR_SYNC(4'hA)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .grant(grant), .busy(busy)
   );

   int checks = 0;
   int failures = 0;

   // Source packet memories: bit 8 is tlast.
   logic [8:0] mem [N][64];
   int head[N], tail[N], start[N], stall_at[N], stall_len[N], hs_cnt[N], gcount[N];
   int cyc, done_cyc, nrdy_from, nrdy_len, hdr_a1_cnt, stall_cnt;
   logic [7:0] log_q[$];
   logic [7:0] e[$];

   // Reference model: owner index (-1 idle), header pending, round-robin pointer.
   int m_owner, m_ptr;
   bit m_hdr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_log(input string name, input logic [7:0] exp[$]);
      chk({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         chk(name, {24'h0, log_q[i]}, {24'h0, exp[i]});
   endtask

   function automatic bit stalled(input int i);
      return hs_cnt[i] == stall_at[i] && stall_len[i] > 0;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         logic v;
         v = (head[i] != tail[i]) && (cyc >= start[i]) && !stalled(i);
         s_tvalid[i]         = v;
         s_tdata[i*DW +: DW] = v ? mem[i][head[i]][7:0] : 8'h00;
         s_tlast[i]          = v ? mem[i][head[i]][8] : 1'b0;
      end
      m_tready = !(cyc >= nrdy_from && cyc < nrdy_from + nrdy_len);
   endtask

   task automatic push(input int src, input logic [7:0] d, input logic last);
      mem[src][tail[src]] = {last, d};
      tail[src]++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0; tail[i] = 0; start[i] = 0; stall_at[i] = -1;
         stall_len[i] = 0; hs_cnt[i] = 0; gcount[i] = 0;
      end
      cyc = 0; nrdy_from = 0; nrdy_len = 0; hdr_a1_cnt = 0; stall_cnt = 0;
      log_q.delete();
      m_owner = -1; m_ptr = N - 1; m_hdr = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step();
      logic [N-1:0]  exp_g, exp_r;
      logic          exp_v;
      logic [DW-1:0] exp_d;
      bit            found;
      @(negedge clk);
      exp_g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      exp_r = '0;
      exp_v = 1'b0;
      exp_d = '0;
      if (m_owner >= 0 && m_hdr) begin
         exp_v = 1'b1;
         exp_d = {4'hA, 4'(m_owner)};
      end else if (m_owner >= 0) begin
         exp_v = s_tvalid[m_owner];
         exp_d = s_tdata[m_owner*DW +: DW];
         exp_r = m_tready ? N'(1 << m_owner) : '0;
      end
      chk("grant", {28'h0, grant}, {28'h0, exp_g});
      chk("busy", {31'h0, busy}, {31'h0, m_owner >= 0});
      chk("m_tvalid", {31'h0, m_tvalid}, {31'h0, exp_v});
      chk("s_tready", {28'h0, s_tready}, {28'h0, exp_r});
      if (exp_v) chk("m_tdata", {24'h0, m_tdata}, {24'h0, exp_d});

      for (int i = 0; i < N; i++) if (grant[i]) gcount[i]++;
      if (m_tvalid && m_tdata == 8'hA1) hdr_a1_cnt++;
      if (busy && !m_tvalid) stall_cnt++;
      if (m_tvalid && m_tready) log_q.push_back(m_tdata);

      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && s_tvalid[(m_ptr + k) % N]) begin
               found   = 1'b1;
               m_owner = (m_ptr + k) % N;
               m_ptr   = m_owner;
               m_hdr   = 1'b1;
            end
         end
      end else if (m_hdr) begin
         if (m_tready) m_hdr = 1'b0;
      end else if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) begin
         m_owner = -1;
      end

      for (int i = 0; i < N; i++) begin
         if (head[i] != tail[i] && stalled(i)) stall_len[i]--;
         if (s_tvalid[i] && s_tready[i]) begin
            head[i]++;
            hs_cnt[i]++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   function automatic bit all_done();
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
      return m_owner < 0;
   endfunction

   task automatic run(input int budget);
      int c;
      for (c = 0; c < budget && !all_done(); c++) step();
      chk("run_timeout", {31'h0, all_done()}, 32'h1);
      done_cyc = cyc;
      step();
   endtask

   initial begin
      s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; rst_n = 1'b0;

      // Reset values
      do_reset();
      @(negedge clk);
      chk("rst_grant", {28'h0, grant}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
      chk("rst_m_tdata", {24'h0, m_tdata}, 32'h0);
      chk("rst_s_tready", {28'h0, s_tready}, 32'h0);

      // Single source 2
      do_reset();
      push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
      drive();
      run(40);
      e = '{8'hA2, 8'h11, 8'h22, 8'h33};
      chk_log("t1_bytes", e);
      chk("t1_grant_cycles", 32'(gcount[2]), 32'd4);

      // Sources 0, 1, 3 continuously requesting
      do_reset();
      for (int p = 0; p < 2; p++) begin
         push(0, 8'(8'h00 + 2*p), 0); push(0, 8'(8'h01 + 2*p), 1);
         push(1, 8'(8'h10 + 2*p), 0); push(1, 8'(8'h11 + 2*p), 1);
         push(3, 8'(8'h30 + 2*p), 0); push(3, 8'(8'h31 + 2*p), 1);
      end
      drive();
      run(100);
      e = '{8'hA0, 8'h00, 8'h01, 8'hA1, 8'h10, 8'h11, 8'hA3, 8'h30, 8'h31,
            8'hA0, 8'h02, 8'h03, 8'hA1, 8'h12, 8'h13, 8'hA3, 8'h32, 8'h33};
      chk_log("t2_bytes", e);
      chk("t2_cycles", 32'(done_cyc), 32'd24);
      chk("t2_src2_grant", 32'(gcount[2]), 32'd0);

      // Header backpressure
      do_reset();
      push(1, 8'h55, 0); push(1, 8'h66, 1);
      nrdy_from = 1; nrdy_len = 5;
      drive();
      run(40);
      e = '{8'hA1, 8'h55, 8'h66};
      chk_log("t3_bytes", e);
      chk("t3_hdr_hold", 32'(hdr_a1_cnt), 32'd6);
      chk("t3_cycles", 32'(done_cyc), 32'd9);

      // Single-beat packet from 3 while 0 waits
      do_reset();
      push(3, 8'hB7, 1);
      push(0, 8'hC0, 0); push(0, 8'hC1, 1);
      start[0] = 1;
      drive();
      run(40);
      e = '{8'hA3, 8'hB7, 8'hA0, 8'hC0, 8'hC1};
      chk_log("t4_bytes", e);
      chk("t4_cycles", 32'(done_cyc), 32'd7);

      // Granted source stalls mid-packet
      do_reset();
      push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 0); push(1, 8'h44, 1);
      push(0, 8'h01, 1);
      start[0] = 2; stall_at[1] = 2; stall_len[1] = 10;
      drive();
      run(60);
      e = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA0, 8'h01};
      chk_log("t5_bytes", e);
      chk("t5_stall_cycles", 32'(stall_cnt), 32'd10);
      chk("t5_cycles", 32'(done_cyc), 32'd19);

      // Reset mid-packet
      do_reset();
      push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 0); push(2, 8'h24, 1);
      drive();
      for (int c = 0; c < 20 && log_q.size() < 3; c++) step();
      chk("t6_pre_bytes", 32'(log_q.size()), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("t6_async_grant", {28'h0, grant}, 32'h0);
      chk("t6_async_busy", {31'h0, busy}, 32'h0);
      chk("t6_async_m_tvalid", {31'h0, m_tvalid}, 32'h0);
      chk("t6_async_s_tready", {28'h0, s_tready}, 32'h0);
      do_reset();
      push(0, 8'h0A, 0); push(0, 8'h0B, 1);
      push(2, 8'h2A, 1);
      drive();
      run(40);
      e = '{8'hA0, 8'h0A, 8'h0B, 8'hA2, 8'h2A};
      chk_log("t6_bytes", e);
      chk("t6_cycles", 32'(done_cyc), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
